// File: rtl/adf4159_pkg.sv
// Shared types and constants for the ADF4159 3-wire serial writer.
package adf4159_pkg;

  localparam int ADF4159_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LE_SETUP,
    LE_PULSE
  } adf4159_state_e;

  // Control-bit field word[2:0] selects the target register R0..R7
  localparam logic [2:0] ADF4159_R0 = 3'd0;
  localparam logic [2:0] ADF4159_R1 = 3'd1;
  localparam logic [2:0] ADF4159_R2 = 3'd2;
  localparam logic [2:0] ADF4159_R3 = 3'd3;
  localparam logic [2:0] ADF4159_R4 = 3'd4;
  localparam logic [2:0] ADF4159_R5 = 3'd5;
  localparam logic [2:0] ADF4159_R6 = 3'd6;
  localparam logic [2:0] ADF4159_R7 = 3'd7;

endpackage

// File: rtl/adf4159_spi_tick.sv
// Restartable divider: raises a one-cycle tick every 'period' ACLK cycles while not cleared.
module adf4159_spi_tick #(
  parameter int W = 3
) (
  input  logic         ACLK,
  input  logic         ARESET,
  input  logic         clear,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] cnt_q;

  assign tick = !clear && (cnt_q == period - W'(1));

  // Wrapping on every tick restarts the count for the next state at the same edge
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/adf4159_spi_writer.sv
// Serialises 32-bit ADF4159 register words onto CLK/DATA/LE, MSB first, then pulses LE.
module adf4159_spi_writer
  import adf4159_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int LE_CYCLES = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [ADF4159_WORD_W-1:0] s_word,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      spi_clk,
  output logic                      spi_data,
  output logic                      spi_le,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                last_addr
);

  localparam int DIV_MAX = (CLK_DIV > LE_CYCLES) ? CLK_DIV : LE_CYCLES;
  localparam int DIV_W   = $clog2(DIV_MAX) + 1;

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("adf4159_spi_writer: CLK_DIV must be >= 1");
  end
  if (LE_CYCLES < 1) begin : g_bad_le_cycles
    $error("adf4159_spi_writer: LE_CYCLES must be >= 1");
  end

  adf4159_state_e              state_q, state_d;
  logic [ADF4159_WORD_W-1:0]   shreg_q;
  logic [5:0]                  bit_cnt_q;
  logic                        sclk_q, le_q, done_q, ready_en_q;
  logic [2:0]                  addr_q, last_addr_q;
  logic                        tick, tick_clear, accept, sclk_rise, sclk_fall;
  logic [DIV_W-1:0]            tick_period;

  assign tick_clear  = (state_q == IDLE);
  assign tick_period = (state_q == LE_PULSE) ? DIV_W'(LE_CYCLES) : DIV_W'(CLK_DIV);

  adf4159_spi_tick #(.W(DIV_W)) u_tick (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .clear  (tick_clear),
    .period (tick_period),
    .tick   (tick)
  );

  assign s_ready   = ready_en_q && (state_q == IDLE);
  assign accept    = s_valid && s_ready;
  assign sclk_rise = (state_q == SHIFT) && tick && !sclk_q;
  assign sclk_fall = (state_q == SHIFT) && tick && sclk_q;

  assign spi_clk   = sclk_q;
  assign spi_data  = shreg_q[ADF4159_WORD_W-1];
  assign spi_le    = le_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign last_addr = last_addr_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = SHIFT;
      SHIFT:    if (sclk_fall && (bit_cnt_q == 6'd31)) state_d = LE_SETUP;
      LE_SETUP: if (tick) state_d = LE_PULSE;
      LE_PULSE: if (tick) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // The last falling edge does not shift, so bit 0 stays on DATA through LE setup and pulse
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      sclk_q      <= 1'b0;
      le_q        <= 1'b0;
      done_q      <= 1'b0;
      ready_en_q  <= 1'b0;
      addr_q      <= '0;
      last_addr_q <= '0;
    end else begin
      ready_en_q <= 1'b1;
      le_q       <= (state_d == LE_PULSE);
      done_q     <= (state_q == LE_PULSE) && (state_d == IDLE);
      if (accept) begin
        shreg_q   <= s_word;
        addr_q    <= s_word[2:0];
        bit_cnt_q <= '0;
      end else if (sclk_rise) begin
        sclk_q <= 1'b1;
      end else if (sclk_fall) begin
        sclk_q    <= 1'b0;
        bit_cnt_q <= bit_cnt_q + 6'd1;
        if (bit_cnt_q != 6'd31) begin
          shreg_q <= {shreg_q[ADF4159_WORD_W-2:0], 1'b0};
        end
      end else if ((state_q == LE_PULSE) && tick) begin
        shreg_q     <= '0;
        last_addr_q <= addr_q;
      end
    end
  end

endmodule
